gray_step_sequencer: RTL and testbench



---
 rtl/gray_step_sequencer.sv | 169 ++++++++++++++++
 tb/tb_gray_step_sequencer.sv | 285 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/gray_step_sequencer.sv
// ---------------------------------------------------------------------------
// gray_step_sequencer
//
// Command-driven controller that walks a WIDTH-bit Gray-code counter through a
// programmed number of single-bit-change steps, up or down. Stepping can be
// paused, and an active command can be aborted. The counter value persists
// across commands; only rst clears it.
//
// Ports
//   clk         rising-edge clock
//   rst         synchronous, active-high reset
//   cmd_valid   command present
//   cmd_ready   command can be accepted (high only in IDLE)
//   cmd_dir     0 = count up, 1 = count down
//   cmd_steps   number of steps to execute (0 is legal)
//   pause       level; freezes stepping while high in RUN
//   abort       level; terminates an active command (wins over pause)
//   gray_out    current Gray value, bin ^ (bin >> 1)
//   bin_out     current binary count
//   steps_left  remaining steps of the active command
//   step_stb    one-cycle pulse: gray_out changed on the last edge
//   busy        high in RUN
//   done        one-cycle completion pulse
//   aborted     qualifies done: command ended by abort
// ---------------------------------------------------------------------------
module gray_step_sequencer #(
    parameter int WIDTH = 4,
    parameter int CNT_W = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             cmd_valid,
    output logic             cmd_ready,
    input  logic             cmd_dir,
    input  logic [CNT_W-1:0] cmd_steps,
    input  logic             pause,
    input  logic             abort,
    output logic [WIDTH-1:0] gray_out,
    output logic [WIDTH-1:0] bin_out,
    output logic [CNT_W-1:0] steps_left,
    output logic             step_stb,
    output logic             busy,
    output logic             done,
    output logic             aborted
);

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_RUN  = 2'd1,
        ST_DONE = 2'd2
    } state_t;

    localparam logic [WIDTH-1:0] BIN_ONE = WIDTH'(1);
    localparam logic [CNT_W-1:0] CNT_ONE = CNT_W'(1);

    state_t             state_reg;
    state_t             state_next;
    logic [WIDTH-1:0]   bin_reg;
    logic [CNT_W-1:0]   steps_left_reg;
    logic               dir_reg;
    logic               step_stb_reg;
    logic               aborted_reg;

    logic               accept;
    logic               do_step;
    logic               do_abort;

    // Handshake and per-edge decisions. Abort beats pause, pause beats step.
    assign accept   = cmd_valid && (state_reg == ST_IDLE);
    assign do_abort = (state_reg == ST_RUN) && abort;
    assign do_step  = (state_reg == ST_RUN) && !abort && !pause;

    // -----------------------------------------------------------------------
    // FSM: state register
    // -----------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (rst) begin
            state_reg <= ST_IDLE;
        end else begin
            state_reg <= state_next;
        end
    end

    // -----------------------------------------------------------------------
    // FSM: next-state logic
    // -----------------------------------------------------------------------
    always_comb begin
        state_next = state_reg;
        case (state_reg)
            ST_IDLE: begin
                if (accept) begin
                    // A zero-step command completes immediately.
                    state_next = (cmd_steps == '0) ? ST_DONE : ST_RUN;
                end
            end
            ST_RUN: begin
                if (do_abort) begin
                    state_next = ST_DONE;
                end else if (do_step && (steps_left_reg == CNT_ONE)) begin
                    state_next = ST_DONE;
                end
            end
            ST_DONE: begin
                state_next = ST_IDLE;
            end
            default: begin
                state_next = ST_IDLE;
            end
        endcase
    end

    // -----------------------------------------------------------------------
    // FSM: outputs decoded from state
    // -----------------------------------------------------------------------
    always_comb begin
        cmd_ready = 1'b0;
        busy      = 1'b0;
        done      = 1'b0;
        case (state_reg)
            ST_IDLE: cmd_ready = 1'b1;
            ST_RUN:  busy      = 1'b1;
            ST_DONE: done      = 1'b1;
            default: cmd_ready = 1'b0;
        endcase
    end

    // -----------------------------------------------------------------------
    // Datapath: counter, step budget and strobes
    // -----------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (rst) begin
            bin_reg        <= '0;
            steps_left_reg <= '0;
            dir_reg        <= 1'b0;
            step_stb_reg   <= 1'b0;
            aborted_reg    <= 1'b0;
        end else begin
            step_stb_reg <= do_step;
            // Only set on the edge entering DONE through abort, so it is
            // high exactly in the done cycle and cleared on the next edge.
            aborted_reg  <= do_abort;
            if (accept) begin
                dir_reg        <= cmd_dir;
                steps_left_reg <= cmd_steps;
            end else if (do_step) begin
                // Natural modulo-2^WIDTH wrap in both directions.
                bin_reg        <= dir_reg ? (bin_reg - BIN_ONE) : (bin_reg + BIN_ONE);
                steps_left_reg <= steps_left_reg - CNT_ONE;
            end
        end
    end

    // -----------------------------------------------------------------------
    // Binary-to-Gray decode: each bit is the XOR of neighbouring binary bits,
    // the MSB passes straight through.
    // -----------------------------------------------------------------------
    generate
        for (genvar gi = 0; gi < WIDTH - 1; gi++) begin : g_gray
            assign gray_out[gi] = bin_reg[gi] ^ bin_reg[gi+1];
        end
    endgenerate
    assign gray_out[WIDTH-1] = bin_reg[WIDTH-1];

    assign bin_out    = bin_reg;
    assign steps_left = steps_left_reg;
    assign step_stb   = step_stb_reg;
    assign aborted    = aborted_reg;

endmodule

// File: tb/tb_gray_step_sequencer.sv
// ---------------------------------------------------------------------------
// tb_gray_step_sequencer
//
// Directed bench for gray_step_sequencer (WIDTH=4, CNT_W=8). A behavioural
// model tracks the command-level behaviour (counter as an integer modulo 16,
// remaining steps, phase) and is compared against every DUT output on each
// falling edge. Directed sequences add literal expectations from the
// hand-computed Gray/binary tables.
// ---------------------------------------------------------------------------
module tb_gray_step_sequencer;

    localparam int WIDTH = 4;
    localparam int CNT_W = 8;
    localparam int MODV  = 1 << WIDTH;

    logic             clk;
    logic             rst;
    logic             cmd_valid;
    logic             cmd_ready;
    logic             cmd_dir;
    logic [CNT_W-1:0] cmd_steps;
    logic             pause;
    logic             abort;
    logic [WIDTH-1:0] gray_out;
    logic [WIDTH-1:0] bin_out;
    logic [CNT_W-1:0] steps_left;
    logic             step_stb;
    logic             busy;
    logic             done;
    logic             aborted;

    int total = 0;
    int bad   = 0;

    gray_step_sequencer #(
        .WIDTH(WIDTH),
        .CNT_W(CNT_W)
    ) dut (
        .clk        (clk),
        .rst        (rst),
        .cmd_valid  (cmd_valid),
        .cmd_ready  (cmd_ready),
        .cmd_dir    (cmd_dir),
        .cmd_steps  (cmd_steps),
        .pause      (pause),
        .abort      (abort),
        .gray_out   (gray_out),
        .bin_out    (bin_out),
        .steps_left (steps_left),
        .step_stb   (step_stb),
        .busy       (busy),
        .done       (done),
        .aborted    (aborted)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string name, input logic [31:0] actual, input logic [31:0] expected);
        total++;
        if (actual !== expected) begin
            bad++;
            $display("FAIL %s: got %0h, want %0h (t=%0t)", name, actual, expected, $time);
        end
    endtask

    function automatic int gray_of(input int b);
        return b ^ (b >> 1);
    endfunction

    // -----------------------------------------------------------------------
    // Behavioural model. Phase: 0 = waiting for a command, 1 = stepping,
    // 2 = reporting completion.
    // -----------------------------------------------------------------------
    int m_phase;
    int m_bin;
    int m_left;
    int m_delta;
    bit m_stb;
    bit m_aborted;

    always @(posedge clk) begin
        if (rst) begin
            m_phase   <= 0;
            m_bin     <= 0;
            m_left    <= 0;
            m_delta   <= 1;
            m_stb     <= 1'b0;
            m_aborted <= 1'b0;
        end else begin
            m_stb     <= 1'b0;
            m_aborted <= 1'b0;
            if (m_phase == 0) begin
                if (cmd_valid) begin
                    m_delta <= cmd_dir ? (MODV - 1) : 1;
                    m_left  <= int'(cmd_steps);
                    m_phase <= (cmd_steps == 0) ? 2 : 1;
                end
            end else if (m_phase == 1) begin
                if (abort) begin
                    m_phase   <= 2;
                    m_aborted <= 1'b1;
                end else if (!pause) begin
                    m_bin  <= (m_bin + m_delta) % MODV;
                    m_left <= m_left - 1;
                    m_stb  <= 1'b1;
                    if (m_left == 1) m_phase <= 2;
                end
            end else begin
                m_phase <= 0;
            end
        end
    end

    // -----------------------------------------------------------------------
    // Per-cycle compare against the model, plus the one-bit-change rule.
    // -----------------------------------------------------------------------
    bit               check_en = 1'b0;
    logic [WIDTH-1:0] prev_gray = '0;

    always @(negedge clk) begin
        if (check_en) begin
            check("bin_out",    32'(bin_out),    32'(m_bin));
            check("gray_out",   32'(gray_out),   32'(gray_of(m_bin)));
            check("steps_left", 32'(steps_left), 32'(m_left));
            check("step_stb",   32'(step_stb),   32'(m_stb));
            check("busy",       32'(busy),       32'(m_phase == 1));
            check("done",       32'(done),       32'(m_phase == 2));
            check("aborted",    32'(aborted),    32'(m_aborted));
            check("cmd_ready",  32'(cmd_ready),  32'(m_phase == 0));
            if (step_stb === 1'b1) begin
                check("one_bit_change", 32'($countones(gray_out ^ prev_gray)), 32'd1);
            end
        end
        prev_gray = gray_out;
    end

    task automatic tick();
        @(negedge clk);
    endtask

    // Present a command for one edge; the caller ensures the DUT is idle.
    task automatic issue(input logic dir, input int n);
        cmd_valid = 1'b1;
        cmd_dir   = dir;
        cmd_steps = CNT_W'(n);
        tick();
        cmd_valid = 1'b0;
        $display("cmd dir=%0d steps=%0d -> bin=%0d gray=%b busy=%0b done=%0b",
                 dir, n, bin_out, gray_out, busy, done);
    endtask

    task automatic wait_done();
        int n = 0;
        while (done !== 1'b1 && n < 200) begin
            tick();
            n++;
        end
        check("wait_done_timeout", 32'(n < 200), 32'd1);
    endtask

    logic [3:0] exp_g5 [5];

    initial begin
        exp_g5[0] = 4'b0001; exp_g5[1] = 4'b0011; exp_g5[2] = 4'b0010;
        exp_g5[3] = 4'b0110; exp_g5[4] = 4'b0111;

        rst = 1'b1; cmd_valid = 1'b0; cmd_dir = 1'b0; cmd_steps = '0;
        pause = 1'b0; abort = 1'b0;
        tick(); tick();
        rst = 1'b0;
        check_en = 1'b1;
        check("reset_gray",  32'(gray_out),  32'd0);
        check("reset_ready", 32'(cmd_ready), 32'd1);
        check("reset_done",  32'(done),      32'd0);

        // Up 5 from 0.
        issue(1'b0, 5);
        for (int i = 0; i < 5; i++) begin
            tick();
            check("up5_gray", 32'(gray_out), 32'(exp_g5[i]));
        end
        check("up5_done", 32'(done), 32'd1);
        check("up5_bin",  32'(bin_out), 32'd5);
        tick();
        check("up5_ready", 32'(cmd_ready), 32'd1);
        $display("txn up5 complete bin=%0d", bin_out);

        // Move to 14, then up 3 across the wrap.
        issue(1'b0, 9);
        wait_done();
        tick();
        check("at14_gray", 32'(gray_out), 32'b1001);
        issue(1'b0, 3);
        tick(); check("wrap_g15", 32'(gray_out), 32'b1000); check("wrap_b15", 32'(bin_out), 32'd15);
        tick(); check("wrap_g0",  32'(gray_out), 32'b0000); check("wrap_b0",  32'(bin_out), 32'd0);
        tick(); check("wrap_g1",  32'(gray_out), 32'b0001); check("wrap_done", 32'(done), 32'd1);
        tick();
        $display("txn wrap-up complete bin=%0d", bin_out);

        // Down 3 from 1.
        issue(1'b1, 3);
        tick(); check("dn_b0",  32'(bin_out), 32'd0);  check("dn_g0",  32'(gray_out), 32'b0000);
        tick(); check("dn_b15", 32'(bin_out), 32'd15); check("dn_g15", 32'(gray_out), 32'b1000);
        tick(); check("dn_b14", 32'(bin_out), 32'd14); check("dn_g14", 32'(gray_out), 32'b1001);
        check("dn_done", 32'(done), 32'd1);
        tick();
        $display("txn down3 complete bin=%0d", bin_out);

        // Up 6 from 14 with a 4-cycle pause after step 2.
        issue(1'b0, 6);
        tick(); tick();
        check("pz_b_before", 32'(bin_out), 32'd0);
        pause = 1'b1;
        for (int i = 0; i < 4; i++) begin
            tick();
            check("pz_frozen", 32'(gray_out), 32'd0);
            check("pz_busy",   32'(busy),     32'd1);
        end
        pause = 1'b0;
        tick(); tick(); tick();
        check("pz_not_done_yet", 32'(done), 32'd0);
        tick();
        check("pz_done", 32'(done),    32'd1);
        check("pz_bin",  32'(bin_out), 32'd4);
        tick();
        $display("txn paused-up6 complete bin=%0d", bin_out);

        // Up 10 from 4, abort (with pause) after 3 steps.
        issue(1'b0, 10);
        tick(); tick(); tick();
        check("ab_bin_pre", 32'(bin_out), 32'd7);
        abort = 1'b1; pause = 1'b1;
        tick();
        check("ab_done",    32'(done),       32'd1);
        check("ab_flag",    32'(aborted),    32'd1);
        check("ab_left",    32'(steps_left), 32'd7);
        check("ab_bin",     32'(bin_out),    32'd7);
        abort = 1'b0; pause = 1'b0;
        tick();
        check("ab_idle_left", 32'(steps_left), 32'd7);
        check("ab_idle_flag", 32'(aborted),    32'd0);
        $display("txn abort complete bin=%0d left=%0d", bin_out, steps_left);

        // Zero-step command.
        issue(1'b0, 0);
        check("z_done", 32'(done),     32'd1);
        check("z_flag", 32'(aborted),  32'd0);
        check("z_gray", 32'(gray_out), 32'b0100);
        tick();
        check("z_ready", 32'(cmd_ready), 32'd1);

        // cmd_valid pulsed during RUN is ignored.
        issue(1'b0, 4);
        tick();
        cmd_valid = 1'b1; cmd_dir = 1'b1; cmd_steps = 8'd9;
        tick();
        cmd_valid = 1'b0;
        wait_done();
        check("ign_bin",  32'(bin_out),    32'd11);
        check("ign_left", 32'(steps_left), 32'd0);
        tick();
        $display("txn ignore-cmd complete bin=%0d", bin_out);

        // Reset mid-command.
        issue(1'b0, 5);
        tick(); tick();
        check("rr_bin_pre", 32'(bin_out), 32'd13);
        rst = 1'b1;
        tick();
        rst = 1'b0;
        check("rr_bin",   32'(bin_out),    32'd0);
        check("rr_busy",  32'(busy),       32'd0);
        check("rr_done",  32'(done),       32'd0);
        check("rr_left",  32'(steps_left), 32'd0);
        check("rr_ready", 32'(cmd_ready),  32'd1);
        tick(); tick(); tick();
        check("rr_no_done", 32'(done), 32'd0);
        $display("txn reset-mid-run complete bin=%0d", bin_out);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
